// File: rtl/aud_freq_pair.sv
// Paired audio frequency divider: two 8-bit channel dividers that can be joined
// into one 16-bit divider, producing the per-channel Timer pulses.
module aud_freq_pair #(
  parameter int FAST8_OFS  = 3,
  parameter int FAST16_OFS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enn,
  input  logic [7:0] D,
  input  logic       AUDF_LO,
  input  logic       AUDF_HI,
  input  logic       STIMER,
  input  logic       join16,
  input  logic       fastLo,
  input  logic       baseTick,
  output logic       TimerLo,
  output logic       TimerHi
);

  logic [7:0]  r_audf_lo, r_audf_hi;
  logic [8:0]  r_cnt_lo, r_cnt_hi;

  logic [7:0]  w_audf_lo, w_audf_hi;
  logic        w_ev_lo;
  logic [8:0]  w_rld_lo, w_rld_hi;
  logic [16:0] w_rld_j, w_cnt_j, w_nxt_j;
  logic        w_uf_lo, w_uf_hi, w_uf_j;

  // Write-through so a write coinciding with a reload loads the new value.
  assign w_audf_lo = AUDF_LO ? D : r_audf_lo;
  assign w_audf_hi = AUDF_HI ? D : r_audf_hi;

  assign w_ev_lo  = fastLo | baseTick;
  assign w_rld_lo = {1'b0, w_audf_lo} + (fastLo ? 9'(FAST8_OFS) : 9'd0);
  assign w_rld_hi = {1'b0, w_audf_hi};
  assign w_rld_j  = {1'b0, w_audf_hi, w_audf_lo} + (fastLo ? 17'(FAST16_OFS) : 17'd0);

  // Joined view: high counter supplies the upper 9 bits, low counter the LSB byte.
  assign w_cnt_j = {r_cnt_hi, r_cnt_lo[7:0]};
  assign w_nxt_j = (w_cnt_j == 17'd0) ? w_rld_j : w_cnt_j - 17'd1;

  assign w_uf_lo = w_ev_lo  && (r_cnt_lo == 9'd0);
  assign w_uf_hi = baseTick && (r_cnt_hi == 9'd0);
  assign w_uf_j  = w_ev_lo  && (w_cnt_j == 17'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_audf_lo <= 8'd0;
      r_audf_hi <= 8'd0;
      r_cnt_lo  <= 9'd0;
      r_cnt_hi  <= 9'd0;
      TimerLo   <= 1'b0;
      TimerHi   <= 1'b0;
    end else if (enn) begin
      if (AUDF_LO) r_audf_lo <= D;
      if (AUDF_HI) r_audf_hi <= D;

      if (STIMER) begin
        if (join16) begin
          r_cnt_hi <= w_rld_j[16:8];
          r_cnt_lo <= {1'b0, w_rld_j[7:0]};
        end else begin
          r_cnt_lo <= w_rld_lo;
          r_cnt_hi <= w_rld_hi;
        end
        TimerLo <= 1'b0;
        TimerHi <= 1'b0;
      end else if (join16) begin
        if (w_ev_lo) begin
          r_cnt_hi <= w_nxt_j[16:8];
          r_cnt_lo <= {1'b0, w_nxt_j[7:0]};
        end
        TimerLo <= 1'b0;
        TimerHi <= w_uf_j;
      end else begin
        if (w_ev_lo)
          r_cnt_lo <= (r_cnt_lo == 9'd0) ? w_rld_lo : r_cnt_lo - 9'd1;
        if (baseTick)
          r_cnt_hi <= (r_cnt_hi == 9'd0) ? w_rld_hi : r_cnt_hi - 9'd1;
        TimerLo <= w_uf_lo;
        TimerHi <= w_uf_hi;
      end
    end
  end

endmodule

// File: tb/tb_aud_freq_pair.sv
// Directed self-checking bench for aud_freq_pair: periods, join, STIMER,
// enn gating and reset behaviour.
module tb_aud_freq_pair;
  logic       clk = 1'b0;
  logic       rst, enn, AUDF_LO, AUDF_HI, STIMER, join16, fastLo, baseTick;
  logic [7:0] D;
  logic       TimerLo, TimerHi;
  int         checks = 0;
  int         errors = 0;

  aud_freq_pair dut (
    .clk(clk), .rst(rst), .enn(enn), .D(D), .AUDF_LO(AUDF_LO), .AUDF_HI(AUDF_HI),
    .STIMER(STIMER), .join16(join16), .fastLo(fastLo), .baseTick(baseTick),
    .TimerLo(TimerLo), .TimerHi(TimerHi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_lo(input logic [7:0] v, input logic st);
    D = v; AUDF_LO = 1'b1; STIMER = st;
    tick();
    AUDF_LO = 1'b0; STIMER = 1'b0;
  endtask

  task automatic wr_hi(input logic [7:0] v);
    D = v; AUDF_HI = 1'b1;
    tick();
    AUDF_HI = 1'b0;
  endtask

  task automatic stimer();
    STIMER = 1'b1;
    tick();
    STIMER = 1'b0;
  endtask

  // Ticks until TimerLo is seen high; -1 if the bound expires.
  task automatic wait_lo(input int start, output int n);
    n = start;
    for (int k = 0; k < 2000; k++) begin
      tick(); n++;
      if (TimerLo) return;
    end
    n = -1;
  endtask

  task automatic wait_hi(output int n, output int lo_seen);
    n = 0; lo_seen = 0;
    for (int k = 0; k < 2000; k++) begin
      tick(); n++;
      if (TimerLo) lo_seen = 1;
      if (TimerHi) return;
    end
    n = -1;
  endtask

  initial begin
    int n, ls;
    logic [7:0]  plo, phi;
    logic [11:0] pg;
    rst = 1'b1; enn = 1'b0; D = 8'd0; AUDF_LO = 1'b0; AUDF_HI = 1'b0; STIMER = 1'b0;
    join16 = 1'b0; fastLo = 1'b0; baseTick = 1'b0;
    tick(); tick();
    chk("reset_lo", TimerLo, 0);
    chk("reset_hi", TimerHi, 0);
    rst = 1'b0;

    // 8-bit base mode: lo=3 -> every 4 ticks, hi=1 -> every 2 ticks
    enn = 1'b1; baseTick = 1'b1;
    wr_lo(8'd3, 1'b0);
    wr_hi(8'd1);
    stimer();
    chk("stimer_clr_lo", TimerLo, 0);
    chk("stimer_clr_hi", TimerHi, 0);
    for (int i = 0; i < 8; i++) begin
      tick(); plo[i] = TimerLo; phi[i] = TimerHi;
    end
    chk("base_lo_pattern", plo, 8'b1000_1000);
    chk("base_hi_pattern", phi, 8'b1010_1010);

    // Fast low channel: audf 0 -> 4, then audf 10 -> 14 after next reload
    fastLo = 1'b1;
    wr_lo(8'd0, 1'b1);
    wait_lo(0, n); chk("fast8_p0_a", n, 4);
    wait_lo(0, n); chk("fast8_p0_b", n, 4);
    wr_lo(8'd10, 1'b0);
    wait_lo(1, n); chk("fast8_old_period", n, 4);
    wait_lo(0, n); chk("fast8_p10", n, 14);

    // Joined fast: 0x0010 -> 23 enn cycles, TimerLo silent
    join16 = 1'b1;
    wr_hi(8'h00);
    wr_lo(8'h10, 1'b0);
    stimer();
    wait_hi(n, ls); chk("join_fast_a", n, 23); chk("join_fast_lo0_a", ls, 0);
    wait_hi(n, ls); chk("join_fast_b", n, 23); chk("join_fast_lo0_b", ls, 0);

    // Joined base: 0x0102 -> 259 ticks
    fastLo = 1'b0;
    wr_hi(8'h01);
    wr_lo(8'h02, 1'b0);
    stimer();
    wait_hi(n, ls); chk("join_base", n, 259); chk("join_base_lo0", ls, 0);

    // Mid-count STIMER with write-through of audfLo=5 on an underflow tick
    join16 = 1'b0;
    wr_lo(8'd3, 1'b0);
    wr_hi(8'd1);
    stimer();
    wait_lo(0, n); chk("pre_stimer_period", n, 4);
    tick(); tick(); tick();
    wr_lo(8'd5, 1'b1);
    chk("stimer_ovr_lo", TimerLo, 0);
    chk("stimer_ovr_hi", TimerHi, 0);
    wait_lo(0, n); chk("stimer_wt_period", n, 6);

    // enn one in three: lo=1 -> pulse held 3 clocks, period 6 clocks
    wr_lo(8'd1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      enn = (i % 3 == 2); baseTick = enn;
      tick(); pg[i] = TimerLo;
    end
    chk("enn_gate_pattern", pg, 12'b1000_1110_0000);

    // Reset mid-count with enn low
    enn = 1'b0; baseTick = 1'b0;
    tick();
    chk("held_enn0", TimerLo, 1);
    rst = 1'b1;
    tick();
    chk("rst_enn0_lo", TimerLo, 0);
    chk("rst_enn0_hi", TimerHi, 0);
    rst = 1'b0; enn = 1'b1; baseTick = 1'b1;
    tick();
    chk("post_rst_lo", TimerLo, 1);
    chk("post_rst_hi", TimerHi, 1);
    tick();
    chk("audf0_every_tick", TimerLo, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aud_freq_pair.md
Name: aud_freq_pair

Overview:
- Paired audio frequency divider; sits directly upstream of two audio control channels.
- Divides the 1.79 MHz enable rate, or a selected base tick (64 kHz/15 kHz), by the AUDF register values.
- Produces the per-channel Timer pulse that each audio control block consumes.
- Supports independent 8-bit operation or one joined 16-bit divider (low channel = LSB, high channel = MSB).

Parameters:
- FAST8_OFS, 3, extra enn cycles added to an 8-bit fast-clock period (period = AUDF+4)
- FAST16_OFS, 6, extra enn cycles added to a 16-bit fast-clock period (period = AUDF16+7)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- enn  input  1  1.79 MHz clock enable; qualifies every non-reset update
- D  input  8  CPU write data
- AUDF_LO  input  1  write strobe, low-channel frequency register
- AUDF_HI  input  1  write strobe, high-channel frequency register
- STIMER  input  1  reload both counters from their registers
- join16  input  1  1 = join the two channels into one 16-bit divider
- fastLo  input  1  1 = low (or joined) counter is clocked by every enn
- baseTick  input  1  selected 64k/15k tick; valid only when enn = 1
- TimerLo  output  1  low-channel underflow pulse
- TimerHi  output  1  high-channel (or joined 16-bit) underflow pulse

Behaviour:
- Reset: when rst = 1 at a clk edge (enn ignored):
  - audfLo, audfHi, cntLo, cntHi <= 0.
  - TimerLo, TimerHi <= 0.
- All other updates occur only on clk edges where enn = 1.
- Writes:
  - An AUDF_LO/AUDF_HI strobe latches D into audfLo/audfHi.
  - The running counter is not disturbed; the new value applies at the next reload.
- Count event per counter:
  - High counter, unjoined: always baseTick.
  - Low counter, and joined 16-bit counter: 1 if fastLo = 1, else baseTick.
- 8-bit mode (join16 = 0), per channel:
  - On a count event with cnt != 0: cnt <= cnt - 1.
  - On a count event with cnt == 0: reload cnt and assert that channel's Timer.
  - Reload value = AUDF, or AUDF + FAST8_OFS for a fast low channel.
  - Counters are 9 bits wide internally.
  - Period: (AUDF+1) count events (base clock); AUDF+4 enn cycles (fast).
- 16-bit mode (join16 = 1):
  - Joined counter = {cntHi, cntLo}, 17 bits wide internally.
  - Reload value = {audfHi, audfLo}, plus FAST16_OFS when fast.
  - Underflow asserts TimerHi only; TimerLo is held at 0.
  - Period: (N+1) base ticks, or N+7 enn cycles when fast.
- Timer outputs:
  - Registered.
  - A pulse is high from the enn edge that produced it until the next enn edge, so each consumer sees exactly one enn-qualified 1.
- STIMER:
  - Reloads all counters with their current reload values and clears both Timers that cycle.
  - Overrides any count event or underflow in the same cycle.
- Simultaneous AUDF write and STIMER: the newly written value is the one loaded (write-through).
- Mode changes mid-count:
  - A change of join16 or fastLo alters only the event source and the reload value.
  - The counter contents are not reset.
  - The new period is exact from the next reload or STIMER.
- AUDF = 0, base clock: a Timer pulse on every base tick.
- Counter wrap below 0 never occurs; reload always takes precedence at 0.
- No combinational path from any input to any output.

Test Plan:
- Base mode, enn = 1 every cycle, baseTick = 1, audfLo = 3, STIMER -> TimerLo high on 1 of every 4 cycles; TimerHi tracks audfHi independently.
- fastLo = 1, audfLo = 0, STIMER -> TimerLo period 4 enn cycles; audfLo = 10 -> period 14 starting after the next reload.
- join16 = 1, fastLo = 1, audfHi = 0x00, audfLo = 0x10, STIMER -> TimerHi period 23 enn cycles; TimerLo constantly 0.
- join16 = 1, base ticks, {hi, lo} = 0x0102 -> TimerHi every 259 base ticks.
- Mid-count STIMER with a simultaneous write of audfLo = 5 -> Timers cleared that cycle; next TimerLo after exactly 6 base ticks.
- enn low for 2 of every 3 cycles -> Timer held 3 clk cycles; state frozen while enn = 0.
- rst asserted mid-count with enn = 0 -> both Timers 0 and counters 0 on the next clk edge; the first pulse after release follows a 0-count event.
